// File: rtl/parallel_to_serial.sv
// Parallel-to-serial shifter with a one-word hold buffer.
// Words arrive over a valid/ready handshake, wait in the hold buffer, and are
// moved into the shifter so consecutive words stream out back-to-back.
module parallel_to_serial #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         serial_out,
    output logic         bit_valid,
    output logic         frame_start,
    output logic         busy
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;
    logic [N-1:0]   r_holdReg;
    logic           r_holdFull;
    logic [N-1:0]   r_shiftReg;
    logic [CW-1:0]  r_count;

    logic           w_lastBit;
    logic           w_take;
    logic           w_fire;
    logic [N-1:0]   w_shifted;
    logic           w_outBit;

    // The hold word moves into the shifter when idle or right after the last
    // bit of the current word, so load_ready depends on registers only.
    assign w_lastBit  = (r_state == SHIFT) && (r_count == LAST_BIT);
    assign w_take     = r_holdFull && ((r_state == IDLE) || w_lastBit);
    assign load_ready = !r_holdFull || w_take;
    assign w_fire     = load_valid && load_ready;

    // Shift direction and output tap follow the chosen bit order.
    always_comb begin
        w_shifted = r_shiftReg;
        w_outBit  = 1'b0;
        if (MSB_FIRST) begin
            w_shifted = {r_shiftReg[N-2:0], 1'b0};
            w_outBit  = r_shiftReg[N-1];
        end else begin
            w_shifted = {1'b0, r_shiftReg[N-1:1]};
            w_outBit  = r_shiftReg[0];
        end
    end

    // State register; reset discards any word in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state: start on a buffered word, leave SHIFT only when the last
    // bit goes out with nothing waiting behind it.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_stateNext = SHIFT;
                end
            end
            SHIFT: begin
                if (w_lastBit && !w_take) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Hold buffer: capture on a handshake, empty when its word is taken
    // without a replacement arriving on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_holdReg  <= '0;
            r_holdFull <= 1'b0;
        end else begin
            if (w_fire) begin
                r_holdReg  <= data_in;
                r_holdFull <= 1'b1;
            end else if (w_take) begin
                r_holdFull <= 1'b0;
            end
        end
    end

    // Shifter and bit counter: reload from the hold buffer at word start,
    // otherwise advance one bit per cycle and wrap the counter at word end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shiftReg <= '0;
            r_count    <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (w_take) begin
                    r_shiftReg <= r_holdReg;
                    r_count    <= '0;
                end
            end else if (w_lastBit) begin
                if (w_take) begin
                    r_shiftReg <= r_holdReg;
                end
                r_count <= '0;
            end else begin
                r_shiftReg <= w_shifted;
                r_count    <= r_count + 1'b1;
            end
        end
    end

    // Moore outputs decoded from registers.
    assign bit_valid   = (r_state == SHIFT);
    assign serial_out  = bit_valid ? w_outBit : 1'b0;
    assign frame_start = bit_valid && (r_count == '0);
    assign busy        = bit_valid || r_holdFull;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed testbench for parallel_to_serial: table-driven single-word check
// for both bit orders, plus hand-written streaming, reset and loopback cases.
module tb_parallel_to_serial;

    logic       clk;
    logic       reset;
    logic [7:0] dataIn;
    logic       loadValid;

    logic loadReady, serialOut, bitValid, frameStart, busy;
    logic loadReadyM, serialOutM, bitValidM, frameStartM, busyM;

    int checks;
    int errors;

    // Loopback deserializer state (LSB-first, 8 bits).
    logic [7:0] rxShift;
    logic [3:0] rxCnt;
    logic       rxDone;

    typedef struct {
        logic       lv;
        logic [7:0] din;
        logic       expSer;
        logic       expSerMsb;
        logic       expBv;
        logic       expFs;
        logic       expBusy;
        logic       expLr;
    } vec_t;

    vec_t vecs [10];

    parallel_to_serial #(.N(8), .MSB_FIRST(1'b0)) dutLsb (
        .clk        (clk),
        .reset      (reset),
        .data_in    (dataIn),
        .load_valid (loadValid),
        .load_ready (loadReady),
        .serial_out (serialOut),
        .bit_valid  (bitValid),
        .frame_start(frameStart),
        .busy       (busy)
    );

    parallel_to_serial #(.N(8), .MSB_FIRST(1'b1)) dutMsb (
        .clk        (clk),
        .reset      (reset),
        .data_in    (dataIn),
        .load_valid (loadValid),
        .load_ready (loadReadyM),
        .serial_out (serialOutM),
        .bit_valid  (bitValidM),
        .frame_start(frameStartM),
        .busy       (busyM)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference deserializer fed by the LSB-first DUT.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rxShift <= 8'h00;
            rxCnt   <= 4'd0;
            rxDone  <= 1'b0;
        end else if (bitValid) begin
            if (frameStart) begin
                rxShift <= {serialOut, 7'b0};
                rxCnt   <= 4'd1;
                rxDone  <= 1'b0;
            end else begin
                rxShift <= {serialOut, rxShift[7:1]};
                rxCnt   <= rxCnt + 4'd1;
                rxDone  <= (rxCnt == 4'd7);
            end
        end else begin
            rxDone <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic lv, input logic [7:0] din);
        loadValid = lv;
        dataIn    = din;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 8'h00);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic setVec(input int i, input logic lv, input logic [7:0] din, input logic s,
                          input logic sm, input logic bv, input logic fs, input logic bz, input logic lr);
        vecs[i].lv = lv;        vecs[i].din = din;
        vecs[i].expSer = s;     vecs[i].expSerMsb = sm;
        vecs[i].expBv = bv;     vecs[i].expFs = fs;
        vecs[i].expBusy = bz;   vecs[i].expLr = lr;
    endtask

    initial begin
        logic [7:0] words2 [3];
        logic [7:0] words6 [4];
        logic [7:0] cur;
        logic       anyBv;
        int         rxIdx;

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        applyStimulus(1'b0, 8'h00);

        // 0xA5 from idle: rows are the state after each edge, edge 0 accepts.
        setVec(0, 1'b1, 8'hA5, 0, 0, 0, 0, 1, 1);
        setVec(1, 1'b0, 8'h00, 1, 1, 1, 1, 1, 1);
        setVec(2, 1'b0, 8'h00, 0, 0, 1, 0, 1, 1);
        setVec(3, 1'b0, 8'h00, 1, 1, 1, 0, 1, 1);
        setVec(4, 1'b0, 8'h00, 0, 0, 1, 0, 1, 1);
        setVec(5, 1'b0, 8'h00, 0, 0, 1, 0, 1, 1);
        setVec(6, 1'b0, 8'h00, 1, 1, 1, 0, 1, 1);
        setVec(7, 1'b0, 8'h00, 0, 0, 1, 0, 1, 1);
        setVec(8, 1'b0, 8'h00, 1, 1, 1, 0, 1, 1);
        setVec(9, 1'b0, 8'h00, 0, 0, 0, 0, 0, 1);

        // Reset state.
        doReset();
        checkOutput("rst_load_ready", loadReady, 1);
        checkOutput("rst_serial_out", serialOut, 0);
        checkOutput("rst_bit_valid", bitValid, 0);
        checkOutput("rst_frame_start", frameStart, 0);
        checkOutput("rst_busy", busy, 0);

        // Single word, both bit orders.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].lv, vecs[i].din);
            tick();
            checkOutput($sformatf("t1_ser_%0d", i), serialOut, vecs[i].expSer);
            checkOutput($sformatf("t5_serMsb_%0d", i), serialOutM, vecs[i].expSerMsb);
            checkOutput($sformatf("t1_bv_%0d", i), bitValid, vecs[i].expBv);
            checkOutput($sformatf("t1_fs_%0d", i), frameStart, vecs[i].expFs);
            checkOutput($sformatf("t5_fsMsb_%0d", i), frameStartM, vecs[i].expFs);
            checkOutput($sformatf("t1_busy_%0d", i), busy, vecs[i].expBusy);
            checkOutput($sformatf("t1_lr_%0d", i), loadReady, vecs[i].expLr);
        end

        // Continuous stream with load_valid held high: accepted at edges 0, 1, 9.
        words2[0] = 8'h3C; words2[1] = 8'hFF; words2[2] = 8'h01;
        applyStimulus(1'b1, words2[0]);
        tick();
        checkOutput("t2_lr_e0", loadReady, 1);
        applyStimulus(1'b1, words2[1]);
        for (int e = 1; e <= 25; e++) begin
            tick();
            if (e <= 24) begin
                cur = words2[(e - 1) / 8];
                checkOutput($sformatf("t2_bv_%0d", e), bitValid, 1);
                checkOutput($sformatf("t2_ser_%0d", e), serialOut, cur[(e - 1) % 8]);
                checkOutput($sformatf("t2_fs_%0d", e), frameStart, ((e - 1) % 8) == 0);
                checkOutput($sformatf("t2_lr_%0d", e), loadReady, !(e <= 15 && (e % 8) != 0));
                checkOutput($sformatf("t2_busy_%0d", e), busy, 1);
            end else begin
                checkOutput("t2_bv_end", bitValid, 0);
                checkOutput("t2_busy_end", busy, 0);
            end
            if (e == 1) applyStimulus(1'b1, words2[2]);
            if (e == 9) applyStimulus(1'b0, 8'h00);
        end

        // 0x81 shifting while 0x7E is offered; 0x7E follows with no gap.
        applyStimulus(1'b1, 8'h81);
        tick();
        applyStimulus(1'b0, 8'h00);
        for (int e = 1; e <= 17; e++) begin
            tick();
            cur = (e <= 8) ? 8'h81 : 8'h7E;
            if (e <= 16) begin
                checkOutput($sformatf("t3_ser_%0d", e), serialOut, cur[(e - 1) % 8]);
                checkOutput($sformatf("t3_fs_%0d", e), frameStart, (e == 1) || (e == 9));
            end
            checkOutput($sformatf("t3_bv_%0d", e), bitValid, e <= 16);
            checkOutput($sformatf("t3_busy_%0d", e), busy, e <= 16);
            checkOutput($sformatf("t3_lr_%0d", e), loadReady, !(e >= 3 && e <= 7));
            if (e == 2) applyStimulus(1'b1, 8'h7E);
            if (e == 3) applyStimulus(1'b0, 8'h00);
        end

        // Reset during bit 4 of 0x55 with 0xAA buffered.
        applyStimulus(1'b1, 8'h55);
        tick();
        applyStimulus(1'b1, 8'hAA);
        tick();
        applyStimulus(1'b0, 8'h00);
        repeat (4) tick();
        checkOutput("t4_bit4_ser", serialOut, 1);
        checkOutput("t4_bit4_busy", busy, 1);
        checkOutput("t4_bit4_lr", loadReady, 0);
        #1 reset = 1'b1;
        #1;
        checkOutput("t4_rst_ser", serialOut, 0);
        checkOutput("t4_rst_bv", bitValid, 0);
        checkOutput("t4_rst_busy", busy, 0);
        checkOutput("t4_rst_lr", loadReady, 1);
        checkOutput("t4_rst_fs", frameStart, 0);
        #1 reset = 1'b0;
        anyBv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            anyBv = anyBv | bitValid | frameStart | busy;
        end
        checkOutput("t4_quiet_after_reset", anyBv, 0);
        applyStimulus(1'b1, 8'hC3);
        tick();
        applyStimulus(1'b0, 8'h00);
        cur = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput($sformatf("t4_new_ser_%0d", i), serialOut, cur[i]);
            checkOutput($sformatf("t4_new_fs_%0d", i), frameStart, i == 0);
        end

        // Loopback into the reference deserializer: accepted at edges 0, 1, 9, 17.
        words6[0] = 8'h12; words6[1] = 8'h34; words6[2] = 8'h56; words6[3] = 8'h78;
        doReset();
        rxIdx = 0;
        applyStimulus(1'b1, words6[0]);
        tick();
        applyStimulus(1'b1, words6[1]);
        for (int e = 1; e <= 36; e++) begin
            tick();
            if (rxDone) begin
                if (rxIdx < 4) begin
                    checkOutput($sformatf("t6_word_%0d", rxIdx), rxShift, words6[rxIdx]);
                    checkOutput($sformatf("t6_edge_%0d", rxIdx), e, 9 + 8 * rxIdx);
                end
                rxIdx++;
            end
            if (e == 1)  applyStimulus(1'b1, words6[2]);
            if (e == 9)  applyStimulus(1'b1, words6[3]);
            if (e == 17) applyStimulus(1'b0, 8'h00);
        end
        checkOutput("t6_word_count", rxIdx, 4);
        checkOutput("t6_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
Upstream serializer that feeds the team's serial-to-parallel deserializer. It accepts N-bit words over a valid/ready handshake, buffers one word, and shifts each word out one bit per clock. Words go out back-to-back with no idle cycles between them. Bit order and frame marker match the deserializer's bit-index order (bit 0 first by default).

Parameters:
N, 8, word width in bits (N >= 2)
MSB_FIRST, 0, 0 = bit 0 transmitted first; 1 = bit N-1 transmitted first

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  N  parallel word to transmit
load_valid  input  1  data_in holds a valid word
load_ready  output  1  block can accept a word this cycle
serial_out  output  1  serial data bit
bit_valid  output  1  serial_out carries a payload bit this cycle
frame_start  output  1  high during the first bit of each word
busy  output  1  word in shifter or hold buffer

Behaviour:
- One clock, clk. reset is asynchronous and active-high.
- Storage:
  - hold_reg (N bits) with hold_full flag, forming a 1-entry buffer.
  - shift_reg (N bits).
  - bit counter count, width clog2(N).
  - state: IDLE or SHIFT.
- Reset values: state = IDLE, hold_full = 0, count = 0, shift_reg = 0, hold_reg = 0.
  - Resulting outputs: load_ready = 1, serial_out = 0, bit_valid = 0, frame_start = 0, busy = 0.
- take = hold_full && (state == IDLE || (state == SHIFT && count == N-1)).
- load_ready = !hold_full || take.
  - Depends on registers only; there is no combinational path from load_valid.
- fire = load_valid && load_ready. On fire, hold_reg <= data_in.
- hold_full next value:
  - fire → 1
  - take without fire → 0
  - neither → unchanged
- Transitions:
  - IDLE: if take → SHIFT, shift_reg <= hold_reg, count <= 0.
  - SHIFT, count < N-1: shift_reg shifts one place toward the output bit; count increments.
  - SHIFT, count == N-1, take: reload shift_reg from hold_reg, count <= 0, stay in SHIFT. No gap between words.
  - SHIFT, count == N-1, no take: → IDLE, count <= 0.
- Output bit:
  - MSB_FIRST = 0: shifter shifts right and emits shift_reg[0].
  - MSB_FIRST = 1: shifter shifts left and emits shift_reg[N-1].
- Outputs are decoded from registers only (Moore):
  - bit_valid = (state == SHIFT)
  - serial_out = output bit when bit_valid, else 0
  - frame_start = bit_valid && count == 0
  - busy = bit_valid || hold_full
- Latency: a word accepted at edge E from IDLE with an empty buffer drives its first bit after edge E+1. Its last bit is driven after edge E+N.
- Throughput: one word per N cycles sustained. load_ready stays low until the last-bit cycle of the current word.
- Simultaneous fire and take on the same edge: the new word enters hold_reg while the old hold word moves to the shifter. hold_full stays 1.
- load_valid while load_ready = 0: data is ignored and nothing changes. The upstream source must hold its word.
- Reset mid-word: all state clears immediately (asynchronously). Partial and buffered words are discarded. No frame_start is issued for the lost word.
- count never exceeds N-1. It wraps to 0 at the end of every word.

Test Plan:
1. Reset, then load 0xA5 (N=8, MSB_FIRST=0) from idle → serial_out sequence 1,0,1,0,0,1,0,1 on cycles E+1..E+8. frame_start high only on the first of these cycles; bit_valid high for exactly 8 cycles.
2. Hold load_valid high with words 0x3C, 0xFF, 0x01 → 24 consecutive bit_valid cycles with no gap. frame_start pulses at cycles 0, 8, 16. load_ready is high only in the last-bit cycle once the buffer is full.
3. Accept 0x81 and, while it shifts, offer 0x7E with load_valid → 0x7E is accepted on the first cycle load_ready is 1. Its bit 0 follows 0x81's bit 7 directly. busy drops to 0 after 16 bits.
4. Assert reset during bit 4 of 0x55 with 0xAA buffered → on the same cycle serial_out = 0, bit_valid = 0, busy = 0, load_ready = 1. After reset release no bits appear until a new word is loaded.
5. MSB_FIRST=1, load 0xA5 → serial_out sequence 1,0,1,0,0,1,0,1 (bit 7 first).
6. Loopback: connect serial_out to a serial-to-parallel deserializer (N=8) and align both from reset with a continuous word stream → the deserializer's parallel output equals each transmitted word, one word per 8 cycles.
